rename_map_ckpt: RTL and testbench

- Parametrised successor to the per-register scoreboard array: a single map table holding, for every architectural integer register, the latest in-flight commit-station tag.
- Accepts NDISP renames per clock and NLOOK combinational source lookups.
- Takes per-branch checkpoints of the whole table, so a mispredict restores the map in one clock instead of rebuilding it during the fetch/decode bubble.
- Sits between decode and the rename lanes; feeds renamed_rsN.

---
 rtl/rename_map_ckpt.sv | 163 ++++++++++++++++
 tb/tb_rename_map_ckpt.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_ckpt.sv
`default_nettype none
// ============================================================================
// Module      : rename_map_ckpt
// Description : Architectural-register rename map with per-branch checkpoints,
//               single-clock mispredict restore and commit-time tag clearing.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_map_ckpt #(
    parameter int NDISP    = 4,
    parameter int NLOOK    = 8,
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5,
    parameter int RA       = 6,
    parameter int NCKPT    = 4,
    parameter int LNCKPT   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NDISP-1:0]          disp_valid,
    input  logic [5*NDISP-1:0]        disp_rd,
    input  logic [LNCOMMIT*NDISP-1:0] disp_tag,
    input  logic [5*NLOOK-1:0]        lookup_rs,
    output logic [RA*NLOOK-1:0]       lookup_out,
    input  logic [NCOMMIT-1:0]        commit_done,
    input  logic                      ckpt_take,
    output logic [LNCKPT-1:0]         ckpt_id,
    output logic                      ckpt_full,
    input  logic                      ckpt_release,
    input  logic                      restore,
    input  logic [LNCKPT-1:0]         restore_id,
    input  logic                      flush,
    output logic                      ckpt_overflow
);

    localparam int                c_NREG = 32;
    localparam logic [LNCKPT:0]   c_FULL = (LNCKPT+1)'(NCKPT);

    logic [c_NREG-1:0]   r_map_valid;
    logic [LNCOMMIT-1:0] r_map_tag  [c_NREG];
    logic [c_NREG-1:0]   r_ckpt_valid [NCKPT];
    logic [LNCOMMIT-1:0] r_ckpt_tag   [NCKPT][c_NREG];
    logic [LNCKPT-1:0]   r_head;
    logic [LNCKPT-1:0]   r_tail;
    logic [LNCKPT:0]     r_count;
    logic                r_overflow;

    logic [c_NREG-1:0]   w_map_valid_nxt;
    logic [LNCOMMIT-1:0] w_map_tag_nxt [c_NREG];
    logic [c_NREG-1:0]   w_ckpt_valid_clr [NCKPT];
    logic                w_rel_ok;
    logic                w_take_ok;
    logic                w_take_ovf;
    logic [LNCKPT-1:0]   w_head_nxt;
    logic [LNCKPT-1:0]   w_rdist;

    assign w_rel_ok   = ckpt_release && (r_count != '0);
    assign w_head_nxt = r_head + LNCKPT'(w_rel_ok);
    assign w_take_ok  = ckpt_take && !restore && (r_count != c_FULL);
    assign w_take_ovf = ckpt_take && !restore && (r_count == c_FULL);
    assign w_rdist    = restore_id - w_head_nxt;

    // Checkpointed copies retire tags exactly like the live map.
    always_comb begin
        for (int k = 0; k < NCKPT; k++) begin
            for (int r = 0; r < c_NREG; r++) begin
                w_ckpt_valid_clr[k][r] = r_ckpt_valid[k][r] && !commit_done[r_ckpt_tag[k][r]];
            end
        end
    end

    // Next-state map: restore replaces the table, otherwise dispatches apply in
    // ascending lane order so the highest lane writing a given rd wins.
    always_comb begin
        for (int r = 0; r < c_NREG; r++) begin
            w_map_valid_nxt[r] = r_map_valid[r] && !commit_done[r_map_tag[r]];
            w_map_tag_nxt[r]   = r_map_tag[r];
        end
        if (restore) begin
            for (int r = 0; r < c_NREG; r++) begin
                w_map_valid_nxt[r] = w_ckpt_valid_clr[restore_id][r];
                w_map_tag_nxt[r]   = r_ckpt_tag[restore_id][r];
            end
        end else begin
            for (int l = 0; l < NDISP; l++) begin
                if (disp_valid[l] && (disp_rd[l*5 +: 5] != 5'd0)) begin
                    w_map_valid_nxt[disp_rd[l*5 +: 5]] = 1'b1;
                    w_map_tag_nxt[disp_rd[l*5 +: 5]]   = disp_tag[l*LNCOMMIT +: LNCOMMIT];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_map_valid <= '0;
            for (int k = 0; k < NCKPT; k++) begin
                r_ckpt_valid[k] <= '0;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_map_valid <= w_map_valid_nxt;
            for (int k = 0; k < NCKPT; k++) begin
                if (w_take_ok && (r_tail == LNCKPT'(k))) begin
                    r_ckpt_valid[k] <= w_map_valid_nxt;
                end else begin
                    r_ckpt_valid[k] <= w_ckpt_valid_clr[k];
                end
            end
            r_head <= w_head_nxt;
            if (restore) begin
                r_tail  <= restore_id + LNCKPT'(1);
                r_count <= {1'b0, w_rdist} + (LNCKPT+1)'(1);
            end else begin
                r_tail  <= r_tail + LNCKPT'(w_take_ok);
                r_count <= r_count + (LNCKPT+1)'(w_take_ok) - (LNCKPT+1)'(w_rel_ok);
            end
            if (w_take_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Tags are qualified by the valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        r_map_tag <= w_map_tag_nxt;
        if (w_take_ok) begin
            r_ckpt_tag[r_tail] <= w_map_tag_nxt;
        end
    end

    generate
        for (genvar p = 0; p < NLOOK; p++) begin : g_lookup
            logic [4:0]    w_rs;
            logic          w_hit;
            logic [RA-2:0] w_body;
            assign w_rs  = lookup_rs[p*5 +: 5];
            assign w_hit = (w_rs != 5'd0) && r_map_valid[w_rs] && !commit_done[r_map_tag[w_rs]];
            always_comb begin
                w_body = '0;
                if (w_hit) begin
                    w_body[LNCOMMIT-1:0] = r_map_tag[w_rs];
                end else begin
                    w_body[4:0] = w_rs;
                end
            end
            assign lookup_out[p*RA +: RA] = {w_hit, w_body};
        end
    endgenerate

    assign ckpt_id       = r_tail;
    assign ckpt_full     = (r_count == c_FULL);
    assign ckpt_overflow = r_overflow;

`ifndef SYNTHESIS
    a_restore_live : assert property (@(posedge clk) disable iff (reset)
        (restore && !flush) |-> ({1'b0, w_rdist} < (r_count - (LNCKPT+1)'(w_rel_ok))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_map_ckpt.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_map_ckpt
// Description : Scoreboard bench for rename_map_ckpt against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_map_ckpt;

    localparam int NDISP = 4, NLOOK = 8, NCOMMIT = 32, LNCOMMIT = 5, RA = 6, NCKPT = 4, LNCKPT = 2;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NDISP-1:0]          disp_valid = '0;
    logic [5*NDISP-1:0]        disp_rd = '0;
    logic [LNCOMMIT*NDISP-1:0] disp_tag = '0;
    logic [5*NLOOK-1:0]        lookup_rs = '0;
    logic [RA*NLOOK-1:0]       lookup_out;
    logic [NCOMMIT-1:0]        commit_done = '0;
    logic                      ckpt_take = 1'b0;
    logic [LNCKPT-1:0]         ckpt_id;
    logic                      ckpt_full;
    logic                      ckpt_release = 1'b0;
    logic                      restore = 1'b0;
    logic [LNCKPT-1:0]         restore_id = '0;
    logic                      flush = 1'b0;
    logic                      ckpt_overflow;

    rename_map_ckpt #(.NDISP(NDISP), .NLOOK(NLOOK), .NCOMMIT(NCOMMIT), .LNCOMMIT(LNCOMMIT),
                      .RA(RA), .NCKPT(NCKPT), .LNCKPT(LNCKPT)) dut (
        .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_rd(disp_rd),
        .disp_tag(disp_tag), .lookup_rs(lookup_rs), .lookup_out(lookup_out),
        .commit_done(commit_done), .ckpt_take(ckpt_take), .ckpt_id(ckpt_id),
        .ckpt_full(ckpt_full), .ckpt_release(ckpt_release), .restore(restore),
        .restore_id(restore_id), .flush(flush), .ckpt_overflow(ckpt_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst, fl, take, rel, rsto;
        bit [1:0]  rid;
        bit [3:0]  dv;
        bit [19:0] rd, tg;
        bit [39:0] rs;
        bit [31:0] cd;
    } stim_t;

    typedef struct {
        logic [47:0] lk;
        logic [1:0]  id;
        logic        full, ovf;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    // Reference model: plain arrays of maps and a checkpoint ring.
    int m_valid[32], m_tag[32];
    int ck_valid[4][32], ck_tag[4][32];
    int head, tail, cnt;
    bit ovf, known = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_valid[r] = 0;
            for (int k = 0; k < 4; k++) ck_valid[k][r] = 0;
        end
        head = 0; tail = 0; cnt = 0; ovf = 0;
    endtask

    task automatic model_step(stim_t s);
        bit rel;
        if (s.rst || s.fl) begin
            model_clear();
            if (s.rst) known = 1;
            return;
        end
        for (int r = 0; r < 32; r++) begin
            if (m_valid[r] != 0 && s.cd[m_tag[r]]) m_valid[r] = 0;
            for (int k = 0; k < 4; k++)
                if (ck_valid[k][r] != 0 && s.cd[ck_tag[k][r]]) ck_valid[k][r] = 0;
        end
        rel = s.rel && cnt > 0;
        if (s.rsto) begin
            for (int r = 0; r < 32; r++) begin
                m_valid[r] = ck_valid[s.rid][r];
                m_tag[r]   = ck_tag[s.rid][r];
            end
            if (rel) head = (head + 1) % 4;
            cnt  = ((int'(s.rid) - head + 4) % 4) + 1;
            tail = (int'(s.rid) + 1) % 4;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (s.dv[l] && s.rd[l*5 +: 5] != 0) begin
                    m_valid[s.rd[l*5 +: 5]] = 1;
                    m_tag[s.rd[l*5 +: 5]]   = s.tg[l*5 +: 5];
                end
            end
            if (s.take) begin
                if (cnt < 4) begin
                    for (int r = 0; r < 32; r++) begin
                        ck_valid[tail][r] = m_valid[r];
                        ck_tag[tail][r]   = m_tag[r];
                    end
                    tail = (tail + 1) % 4;
                    cnt++;
                end else begin
                    ovf = 1;
                end
            end
            if (rel) begin
                head = (head + 1) % 4;
                cnt--;
            end
        end
    endtask

    task automatic drv(stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset = s.rst; flush = s.fl; ckpt_take = s.take; ckpt_release = s.rel;
        restore = s.rsto; restore_id = s.rid; disp_valid = s.dv; disp_rd = s.rd;
        disp_tag = s.tg; lookup_rs = s.rs; commit_done = s.cd;
        if (known) begin
            for (int p = 0; p < 8; p++) begin
                int r;
                r = int'(s.rs[p*5 +: 5]);
                if (r != 0 && m_valid[r] != 0 && !s.cd[m_tag[r]])
                    e.lk[p*6 +: 6] = {1'b1, 5'(m_tag[r])};
                else
                    e.lk[p*6 +: 6] = {1'b0, 5'(r)};
            end
            e.id   = 2'(tail);
            e.full = (cnt == 4);
            e.ovf  = ovf;
            q.push_back(e);
        end
        model_step(s);
    endtask

    // Monitor: every clock the DUT presents lookups and checkpoint status.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (lookup_out !== e.lk) begin
                errors++;
                $display("FAIL lookup_out rs=%h got=%h exp=%h", lookup_rs, lookup_out, e.lk);
            end
            checks++;
            if (ckpt_id !== e.id) begin
                errors++;
                $display("FAIL ckpt_id got=%0d exp=%0d", ckpt_id, e.id);
            end
            checks++;
            if (ckpt_full !== e.full) begin
                errors++;
                $display("FAIL ckpt_full got=%b exp=%b", ckpt_full, e.full);
            end
            checks++;
            if (ckpt_overflow !== e.ovf) begin
                errors++;
                $display("FAIL ckpt_overflow got=%b exp=%b", ckpt_overflow, e.ovf);
            end
        end
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1; drv(s);
        s = idle(); s.rs[4:0] = 5; drv(s);
        s = idle(); s.dv = 4'b0001; s.rd[4:0] = 5; s.tg[4:0] = 7; drv(s);
        s = idle(); s.rs[4:0] = 5; drv(s);
        s = idle(); s.rs[4:0] = 5; s.cd[7] = 1; drv(s);
        s = idle(); s.dv = 4'b1011; s.rd = {5'd9, 5'd0, 5'd0, 5'd9}; s.tg = {5'd11, 5'd0, 5'd3, 5'd2}; drv(s);
        s = idle(); s.rs[9:0] = {5'd0, 5'd9}; drv(s);
        s = idle(); s.dv = 4'b0001; s.rd[4:0] = 3; s.tg[4:0] = 4; s.take = 1; drv(s);
        s = idle(); s.dv = 4'b0001; s.rd[4:0] = 3; s.tg[4:0] = 9; s.rs[4:0] = 3; drv(s);
        s = idle(); s.rsto = 1; s.rid = 0; s.rs[4:0] = 3; drv(s);
        s = idle(); s.rs[4:0] = 3; drv(s);
        s = idle(); s.dv = 4'b0001; s.rd[4:0] = 6; s.tg[4:0] = 12; s.take = 1; drv(s);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.take = 1; drv(s);
        end
        s = idle(); s.rel = 1; drv(s);
        s = idle(); s.rel = 1; s.cd[12] = 1; s.rs[4:0] = 6; drv(s);
        s = idle(); s.take = 1; drv(s);
        s = idle(); s.take = 1; drv(s);
        s = idle(); s.rsto = 1; s.rid = 2'(head); s.rs[4:0] = 6; drv(s);
        s = idle(); s.rs[4:0] = 6; s.take = 1; drv(s);
        s = idle(); s.fl = 1; s.dv = 4'b0001; s.rd[4:0] = 7; s.tg[4:0] = 1; s.rsto = 1; s.rid = 2'(head); drv(s);
        s = idle(); s.rs = {5'd9, 5'd7, 5'd6, 5'd5, 5'd3, 5'd2, 5'd1, 5'd0}; drv(s);
        s = idle(); s.dv = 4'b0001; s.rd[4:0] = 8; s.tg[4:0] = 20; drv(s);
        s = idle(); s.rst = 1; s.rs[4:0] = 8; drv(s);
        s = idle(); s.rs[4:0] = 8; drv(s);

        for (int i = 0; i < 2500; i++) begin
            int avail;
            bit rel_eff;
            s = idle();
            s.rst  = ($urandom_range(0, 299) == 0);
            s.fl   = ($urandom_range(0, 79) == 0);
            s.dv   = 4'($urandom);
            for (int l = 0; l < 4; l++) begin
                s.rd[l*5 +: 5] = 5'($urandom_range(0, 11));
                s.tg[l*5 +: 5] = 5'($urandom_range(0, 31));
            end
            for (int p = 0; p < 8; p++) s.rs[p*5 +: 5] = 5'($urandom_range(0, 13));
            repeat ($urandom_range(0, 2)) s.cd[$urandom_range(0, 31)] = 1'b1;
            s.take = ($urandom_range(0, 3) == 0);
            s.rel  = ($urandom_range(0, 4) == 0);
            rel_eff = s.rel && cnt > 0;
            avail = cnt - int'(rel_eff);
            if (avail > 0 && $urandom_range(0, 11) == 0) begin
                s.rsto = 1;
                s.rid  = 2'((head + int'(rel_eff) + $urandom_range(0, avail - 1)) % 4);
            end
            drv(s);
        end

        s = idle(); drv(s);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
